// File: rtl/arb8_mux_sched.sv
// Round-robin arbiter driving the select lines of a shared 8:1 single-bit mux.
// Owners keep the grant for up to HOLD_MAX cycles while others wait; lone owners keep it.
module arb8_mux_sched #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [7:0] grant,
   output logic [2:0] sel,
   output logic       valid,
   output logic       dout
);

   localparam int unsigned N      = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned HOLD_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state, state_nx;
   logic [SEL_W-1:0]    ptr, ptr_nx;
   logic [HOLD_W-1:0]   hold_cnt, hold_nx;
   logic [N-1:0]        grant_nx;
   logic [SEL_W-1:0]    sel_nx;
   logic                valid_nx;
   logic [N-1:0]        others;
   logic [SEL_W-1:0]    succ;
   logic                hold_full;
   logic                release_c;

   // First set bit of vec scanning circularly upward from start.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0] vec,
                                                input logic [SEL_W-1:0] start);
      logic [SEL_W-1:0] idx;
      logic             hit;
      rr_pick = start;
      hit     = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = start + SEL_W'(i);
         if (!hit && vec[idx]) begin
            rr_pick = idx;
            hit     = 1'b1;
         end
      end
   endfunction

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         grant    <= '0;
         sel      <= '0;
         valid    <= 1'b0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_nx;
         grant    <= grant_nx;
         sel      <= sel_nx;
         valid    <= valid_nx;
      end
   end

   // Next-state and arbitration decision.
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      hold_nx   = hold_cnt;
      grant_nx  = grant;
      sel_nx    = sel;
      valid_nx  = valid;
      others    = req & ~(N'(1) << sel);
      succ      = sel + SEL_W'(1);
      hold_full = (hold_cnt == HOLD_W'(HOLD_MAX));
      release_c = !req[sel] || (hold_full && (others != '0));

      unique case (state)
         IDLE: begin
            if (req != '0) begin
               sel_nx   = rr_pick(req, ptr);
               grant_nx = N'(1) << rr_pick(req, ptr);
               valid_nx = 1'b1;
               hold_nx  = HOLD_W'(1);
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (release_c) begin
               ptr_nx = succ;
               if (others != '0) begin
                  // Hand over in the same edge so the mux never idles.
                  sel_nx   = rr_pick(others, succ);
                  grant_nx = N'(1) << rr_pick(others, succ);
                  valid_nx = 1'b1;
                  hold_nx  = HOLD_W'(1);
               end else begin
                  grant_nx = '0;
                  valid_nx = 1'b0;
                  hold_nx  = '0;
                  state_nx = IDLE;
               end
            end else if (!hold_full) begin
               hold_nx = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
            valid_nx = 1'b0;
         end
      endcase
   end

   assign dout = valid & din[sel];

endmodule

// File: tb/tb_arb8_mux_sched.sv
// Directed bench for arb8_mux_sched with HOLD_MAX=4; outputs sampled on the falling edge.
module tb_arb8_mux_sched;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic       dout;

   int checks_total;
   int checks_passed;

   arb8_mux_sched #(.HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .din   (din),
      .grant (grant),
      .sel   (sel),
      .valid (valid),
      .dout  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      din   = 8'h00;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      din   = 8'hFF;
      step();
      step();
      checks_total++;
      if (grant !== 8'h00) $display("FAIL reset_grant got %h want 00", grant);
      else checks_passed++;
      checks_total++;
      if (sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel);
      else checks_passed++;
      checks_total++;
      if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid);
      else checks_passed++;
      checks_total++;
      if (dout !== 1'b0) $display("FAIL reset_dout got %b want 0", dout);
      else checks_passed++;
      rst_n = 1'b1;
      step();
      checks_total++;
      if (grant !== 8'h01) $display("FAIL reset_first_grant got %h want 01", grant);
      else checks_passed++;
   endtask

   task automatic test_single();
      do_reset();
      req = 8'h08;
      din = 8'h08;
      step();
      checks_total++;
      if (grant !== 8'h08) $display("FAIL single_grant got %h want 08", grant);
      else checks_passed++;
      checks_total++;
      if (sel !== 3'd3) $display("FAIL single_sel got %0d want 3", sel);
      else checks_passed++;
      checks_total++;
      if (valid !== 1'b1) $display("FAIL single_valid got %b want 1", valid);
      else checks_passed++;
      checks_total++;
      if (dout !== 1'b1) $display("FAIL single_dout got %b want 1", dout);
      else checks_passed++;
      din = 8'hF7;
      #1;
      checks_total++;
      if (dout !== 1'b0) $display("FAIL single_dout_comb got %b want 0", dout);
      else checks_passed++;
   endtask

   task automatic test_rotation();
      logic [7:0] exp_g;
      logic [2:0] exp_s;
      do_reset();
      req = 8'h81;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_g = (i < 4) ? 8'h01 : (i < 8) ? 8'h80 : 8'h01;
         exp_s = (i < 4) ? 3'd0 : (i < 8) ? 3'd7 : 3'd0;
         checks_total++;
         if (grant !== exp_g) $display("FAIL rotate_grant cyc %0d got %h want %h", i, grant, exp_g);
         else checks_passed++;
         checks_total++;
         if (sel !== exp_s) $display("FAIL rotate_sel cyc %0d got %0d want %0d", i, sel, exp_s);
         else checks_passed++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req = 8'h06;
      din = 8'h04;
      step();
      checks_total++;
      if (grant !== 8'h02) $display("FAIL b2b_first got %h want 02", grant);
      else checks_passed++;
      checks_total++;
      if (dout !== 1'b0) $display("FAIL b2b_dout1 got %b want 0", dout);
      else checks_passed++;
      req = 8'h04;
      @(posedge clk);
      #1;
      checks_total++;
      if (valid !== 1'b1) $display("FAIL b2b_valid_gap got %b want 1", valid);
      else checks_passed++;
      @(negedge clk);
      checks_total++;
      if (grant !== 8'h04) $display("FAIL b2b_second got %h want 04", grant);
      else checks_passed++;
      checks_total++;
      if (sel !== 3'd2) $display("FAIL b2b_sel got %0d want 2", sel);
      else checks_passed++;
      checks_total++;
      if (dout !== 1'b1) $display("FAIL b2b_dout2 got %b want 1", dout);
      else checks_passed++;
      req = 8'h00;
      step();
      checks_total++;
      if ((valid !== 1'b0) || (grant !== 8'h00) || (dout !== 1'b0))
         $display("FAIL b2b_idle got v=%b g=%h d=%b want 0/00/0", valid, grant, dout);
      else checks_passed++;
   endtask

   task automatic test_saturation();
      do_reset();
      req = 8'h20;
      for (int i = 0; i < 12; i++) begin
         step();
         checks_total++;
         if (grant !== 8'h20) $display("FAIL sat_hold cyc %0d got %h want 20", i, grant);
         else checks_passed++;
      end
      req = 8'h21;
      step();
      checks_total++;
      if (grant !== 8'h01) $display("FAIL sat_rotate got %h want 01", grant);
      else checks_passed++;
      checks_total++;
      if (sel !== 3'd0) $display("FAIL sat_sel got %0d want 0", sel);
      else checks_passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 8'h08;
      step();
      req = 8'h04;
      step();
      checks_total++;
      if (grant !== 8'h04) $display("FAIL mid_pre got %h want 04", grant);
      else checks_passed++;
      rst_n = 1'b0;
      step();
      checks_total++;
      if ((grant !== 8'h00) || (sel !== 3'd0) || (valid !== 1'b0))
         $display("FAIL mid_reset got g=%h s=%0d v=%b want 00/0/0", grant, sel, valid);
      else checks_passed++;
      rst_n = 1'b1;
      req   = 8'h0C;
      step();
      checks_total++;
      if (grant !== 8'h04) $display("FAIL mid_after got %h want 04", grant);
      else checks_passed++;
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst_n = 1'b0;
      req   = 8'h00;
      din   = 8'h00;
      @(negedge clk);
      test_reset();
      test_single();
      test_rotation();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/arb8_mux_sched.md
# arb8_mux_sched

Round-robin arbiter and scheduler that shares one 8:1 single-bit multiplexer among eight requesters. It samples a request vector, issues a registered one-hot grant and the matching 3-bit select code, and routes the granted requester's data bit to a single output. Each owner may hold the grant for a bounded number of cycles before it is forced to rotate. The block sits in front of the 8:1 mux datapath and is its only driver of the select lines.

## Interface
- HOLD_MAX, 4: maximum consecutive granted cycles per owner while other requests are pending; legal range 1..15 (4-bit hold counter).

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req  in  8  request vector; bit i = requester i
- din  in  8  data bits into the mux; bit i = requester i's data
- grant  out  8  registered one-hot grant; all zero when idle
- sel  out  3  registered select code = index of the granted requester; S2..S0 of the mux
- valid  out  1  high while any grant is active (= |grant)
- dout  out  1  din[sel] when valid, else 0 (combinational from registered sel)

## Operation
- Internal state:
  - FSM states: IDLE, GRANT.
  - Round-robin pointer ptr[2:0].
  - Hold counter hold_cnt[3:0].
  - Owner index o, which equals sel.
- Reset (rst_n low at a rising edge):
  - Outputs: grant=0x00, sel=0, valid=0, dout=0.
  - Internal: state IDLE, ptr=0, hold_cnt=0.
  - Reset overrides all request activity, including mid-grant.
- Search function: the first set bit of a candidate vector, scanning circularly upward from a start index, wrapping 7→0.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, search req starting at ptr, then at the edge:
    - grant the found index n and set sel=n;
    - set hold_cnt=1 and enter GRANT.
- GRANT, evaluated at each edge with owner o and others = req with bit o cleared:
  - Release condition: req[o]==0, OR (hold_cnt==HOLD_MAX AND others≠0).
  - On release:
    - set ptr=(o+1) mod 8;
    - if others≠0, grant the search of others from (o+1) mod 8 and set hold_cnt=1 (no idle bubble);
    - otherwise, go to IDLE with grant=0.
  - Otherwise, keep owner o and set hold_cnt = min(hold_cnt+1, HOLD_MAX).
  - A lone requester keeps the grant indefinitely; the counter saturates at HOLD_MAX and never wraps.
- Outputs:
  - grant, sel and valid change only on clock edges.
  - dout tracks din[sel] combinationally within a cycle.
- Simultaneous events:
  - The owner dropping req in the same cycle that others assert is a normal release.
  - The new owner is chosen from that same sampled req.
- HOLD_MAX=1: the grant rotates every cycle whenever more than one request is pending.

## Timing
- Grant latency: a req sampled at edge k produces grant/sel/valid after edge k when the block is idle.
- Release latency: an owner deasserting req before edge k loses the grant after edge k. Any successor is granted at that same edge.
- Fairness: with all requests held, each owner gets exactly HOLD_MAX cycles, in index order with wrap.
- Worst-case wait for a continuously requesting input: 7·HOLD_MAX cycles.
- One-hot invariant: grant has at most one bit set and is consistent with sel every cycle.
- valid==0 implies grant==0 and dout==0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=0xFF, din=0xFF → grant=0x00, sel=0, valid=0, dout=0. After release, first grant=0x01.
- Single requester: req=0x08, din=0x08 → one edge later grant=0x08, sel=3, valid=1, dout=1. Then toggle din[3] to 0 → dout=0 in the same cycle.
- Forced rotation with wrap, HOLD_MAX=4: from reset, req=0x81 held → grant=0x01 for 4 cycles, then 0x80 for 4 cycles, then 0x01 again.
- Early release without bubble: req=0x06 → grant=0x02. Clear req[1] → grant=0x04, sel=2 at the next edge, with valid never low.
- Lone-owner saturation: req=0x20 held 12 cycles → grant=0x20 every cycle. Then assert req[0] → grant moves to 0x01 at the next edge, because hold_cnt is already saturated.
- Reset mid-operation: during grant=0x04, drive rst_n=0 for one edge → grant=0x00, sel=0, valid=0. After release with req=0x0C → grant=0x04, since ptr was reset to 0.
